quan_frame_ctrl: RTL and testbench
==================================

# quan_frame_ctrl

Forward-quantization frame controller for the encode path. On a `start` pulse it reads one frame of 16-bit offset-binary PCM samples from the sample BRAM. Each sample is quantized to a 4-bit signed code and written to the code BRAM at the same address. A one-cycle `intr` is raised when the frame is complete. It is the writer of the code memory that the inverse-quantization path later reads.

## Interface
Parameters:
- `FRAME_LEN`, 256: samples per frame; must satisfy FRAME_LEN ≤ 2^ADDR_W.
- `ADDR_W`, 9: address width of both BRAMs.
- `SHIFT`, 12: quantizer right-shift, legal range 1..12.

Ports:
- `clk_in`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle frame request.
- `busy`  out  1  high from the first RUN cycle through the DONE cycle.
- `intr`  out  1  frame-done pulse, exactly one cycle.
- `en_pcm`  out  1  PCM BRAM read enable.
- `addr_pcm`  out  ADDR_W  PCM read address.
- `pcm_data`  in  16  PCM read data, offset binary; 1-cycle read latency.
- `ena_q`  out  1  code BRAM enable; always equal to `wea_q`.
- `wea_q`  out  1  code BRAM write enable.
- `addra_q`  out  ADDR_W  code write address.
- `dina_q`  out  4  quantized code, two's complement.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when `start` = 1. `start` is ignored in every other state.
- RUN lasts FRAME_LEN cycles. `en_pcm` = 1 and `addr_pcm` steps 0..FRAME_LEN-1, one per cycle. RUN -> DRAIN after the cycle with address FRAME_LEN-1.
- DRAIN lasts 2 cycles, flushing the read/quantize pipeline, then -> DONE.
- DONE lasts 1 cycle with `intr` = 1, then -> IDLE. `addr_pcm` returns to 0 in IDLE and never wraps inside a frame.
- Quantizer, per sample:
  - s = pcm_data with MSB inverted, i.e. pcm_data − 0x8000 read as signed 16-bit.
  - r = (s + 2^(SHIFT−1)) >>> SHIFT, computed in 17 bits (round half up).
  - `dina_q` = r saturated to [−8, +7].
- Write pipeline:
  - Stage 1: capture `pcm_data` together with the address delayed by one cycle.
  - Stage 2: register the code, the address and the write enable.
  - Every sample read produces exactly one write to the same address.
- Reset (`rst` = 1 at a rising edge): state -> IDLE; all outputs and pipeline registers become 0 on that edge. A partially processed frame is abandoned with no `intr` and no further writes.

## Timing
- Reset values: `busy`, `intr`, `en_pcm`, `wea_q`, `ena_q` = 0; `addr_pcm`, `addra_q`, `dina_q` = 0.
- Cycle T: `start` sampled high in IDLE.
- T+1..T+FRAME_LEN: RUN. `addr_pcm` = k at T+1+k.
- Data for address k is valid on `pcm_data` at T+2+k.
- `wea_q` = 1 with `addra_q` = k at T+3+k. Writes cover T+3..T+FRAME_LEN+2; FRAME_LEN consecutive write cycles, no gaps.
- T+FRAME_LEN+1..T+FRAME_LEN+2: DRAIN.
- T+FRAME_LEN+3: DONE, `intr` = 1.
- T+FRAME_LEN+4: IDLE. A `start` in this cycle is accepted.
- `busy` is high T+1..T+FRAME_LEN+3.
- With default parameters, start-to-`intr` latency is 259 cycles.

## Structure
- Shared package `audio_pkg`:
  - state enum, {IDLE, RUN, DRAIN, DONE}.
  - constants PCM_W = 16, CODE_W = 4, PCM_OFFSET = 16'h8000, CODE_MAX = 7, CODE_MIN = −8.
- Sub-module `fwd_quan`: combinational quantizer with input pcm[15:0] (offset binary), parameter SHIFT, output code[3:0]. It is the counterpart of the existing inverse quantizer. The controller instantiates it between pipeline stages 1 and 2.

## Test plan
1. Reset: assert `rst` for 3 cycles with random `start` -> all outputs 0 and `busy` = 0 throughout.
2. Frame timing: `start` at T with FRAME_LEN = 256 -> exactly 256 writes to addresses 0..255 in order at T+3..T+258; `intr` high only at T+259; `busy` high T+1..T+259.
3. Quantizer values, SHIFT = 12:
   - 0x0000 -> 0x8 (−8)
   - 0x8000 -> 0
   - 0x87FF -> 0
   - 0x8800 -> 1
   - 0xFFFF -> 7 (saturated)
   - 0x7800 -> 0 (−2048 + 2048 = 0)
4. Quantizer values, SHIFT = 8:
   - 0x8180 -> 2
   - 0x9000 -> 7 (saturated from 16)
   - 0x7000 -> −8 (saturated from −16)
5. `start` handling:
   - `start` pulses at T+50 and in the DONE cycle -> ignored; only one frame of writes.
   - `start` at T+260 (IDLE) -> second frame begins at T+261.
6. Mid-frame reset: `rst` at the cycle with `addr_pcm` = 100 -> next cycle all outputs 0 and state IDLE; no `intr`; no write after the reset edge; a subsequent `start` yields a full 256-write frame and `intr`.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio encode/decode datapath.
//   state_e    : frame-controller state encoding
//   PCM_W      : PCM sample width (offset binary)
//   CODE_W     : quantized code width (two's complement)
//   PCM_OFFSET : offset-binary zero point
//   CODE_MAX / CODE_MIN : saturation limits of the quantized code
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int          PCM_W      = 16;
    localparam int          CODE_W     = 4;
    localparam logic [15:0] PCM_OFFSET = 16'h8000;
    localparam int          CODE_MAX   = 7;
    localparam int          CODE_MIN   = -8;

endpackage

// File: rtl/fwd_quan.sv
// Forward quantizer (combinational).
//   pcm  [15:0] in  : offset-binary PCM sample
//   code [3:0]  out : rounded, saturated two's-complement code
// code = sat(((pcm - 0x8000) + 2^(SHIFT-1)) >>> SHIFT), round half up.
// Counterpart of the inverse quantizer on the decode path.
module fwd_quan
    import audio_pkg::*;
#(
    parameter int SHIFT = 12
) (
    input  logic [PCM_W-1:0]  pcm,
    output logic [CODE_W-1:0] code
);

    // 17 bits are enough: the largest sum is 32767 + 2048 with no overflow.
    localparam logic signed [PCM_W:0] ROUND = (PCM_W+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [PCM_W:0] R_MAX = (PCM_W+1)'(CODE_MAX);
    localparam logic signed [PCM_W:0] R_MIN = (PCM_W+1)'(CODE_MIN);

    logic [PCM_W-1:0]        s;
    logic signed [PCM_W:0]   s_ext;
    logic signed [PCM_W:0]   sum;
    logic signed [PCM_W:0]   r;

    always_comb begin
        // Inverting the MSB turns offset binary into two's complement.
        s     = pcm ^ PCM_OFFSET;
        s_ext = signed'({s[PCM_W-1], s});
        sum   = s_ext + ROUND;
        r     = sum >>> SHIFT;
        if (r > R_MAX) begin
            code = CODE_W'(CODE_MAX);
        end else if (r < R_MIN) begin
            code = CODE_W'(CODE_MIN);
        end else begin
            code = r[CODE_W-1:0];
        end
    end

endmodule

// File: rtl/quan_frame_ctrl.sv
// Forward-quantization frame controller.
// On start, reads FRAME_LEN PCM samples from the sample BRAM, quantizes each
// to a 4-bit code and writes it to the code BRAM at the same address, then
// pulses intr for one cycle.
//   clk_in, rst          : clock, synchronous active-high reset
//   start                : frame request (honoured only in IDLE)
//   busy, intr           : activity flag, one-cycle frame-done pulse
//   en_pcm, addr_pcm     : PCM BRAM read port (1-cycle latency)
//   pcm_data             : PCM read data, offset binary
//   ena_q, wea_q,
//   addra_q, dina_q      : code BRAM write port
module quan_frame_ctrl
    import audio_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 9,
    parameter int SHIFT     = 12
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              intr,
    output logic              en_pcm,
    output logic [ADDR_W-1:0] addr_pcm,
    input  logic [PCM_W-1:0]  pcm_data,
    output logic              ena_q,
    output logic              wea_q,
    output logic [ADDR_W-1:0] addra_q,
    output logic [CODE_W-1:0] dina_q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                drain_q, drain_d;

    // Stage 1: read-valid and address aligned with pcm_data.
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

    // Stage 2: registered write port.
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [CODE_W-1:0]   code_q, code_d;

    logic [CODE_W-1:0]   code_comb;

    fwd_quan #(
        .SHIFT (SHIFT)
    ) u_fwd_quan (
        .pcm  (pcm_data),
        .code (code_comb)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles let the last read and its write clear the pipe.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_comb begin
        rd_valid_d = (state_q == RUN);
        rd_addr_d  = addr_q;
        wr_en_d    = rd_valid_q;
        wr_addr_d  = rd_addr_q;
        code_d     = rd_valid_q ? code_comb : code_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            drain_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            code_q     <= code_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign intr     = (state_q == DONE);
    assign en_pcm   = (state_q == RUN);
    assign addr_pcm = addr_q;
    assign wea_q    = wr_en_q;
    assign ena_q    = wr_en_q;
    assign addra_q  = wr_addr_q;
    assign dina_q   = code_q;

endmodule

// File: tb/tb_quan_frame_ctrl.sv
module tb_quan_frame_ctrl;

    localparam int FRAME_LEN = 256;
    localparam int ADDR_W    = 9;

    logic              clk_in = 1'b0;
    logic              rst    = 1'b1;
    logic              start  = 1'b0;
    logic              busy, intr, en_pcm, ena_q, wea_q;
    logic [ADDR_W-1:0] addr_pcm, addra_q;
    logic [15:0]       pcm_data = 16'h0000;
    logic [3:0]        dina_q;

    logic [15:0]       q8_pcm = 16'h8000;
    logic [3:0]        q8_code;

    int tests_run = 0;
    int fails     = 0;

    logic [15:0] pcm_mem [0:(1<<ADDR_W)-1];
    // Sample pattern and its hand-computed SHIFT=12 codes.
    logic [15:0] pat_pcm  [0:9] = '{16'h0000, 16'h8000, 16'h87FF, 16'h8800, 16'hFFFF,
                                    16'h7800, 16'h9000, 16'h7000, 16'hC000, 16'h4000};
    logic [3:0]  pat_code [0:9] = '{4'h8, 4'h0, 4'h0, 4'h1, 4'h7,
                                    4'h0, 4'h1, 4'hF, 4'h4, 4'hC};

    always #5 clk_in = ~clk_in;

    // 1-cycle-latency PCM BRAM model
    always @(posedge clk_in) begin
        if (en_pcm) pcm_data <= pcm_mem[addr_pcm];
    end

    quan_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W),
        .SHIFT     (12)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .intr     (intr),
        .en_pcm   (en_pcm),
        .addr_pcm (addr_pcm),
        .pcm_data (pcm_data),
        .ena_q    (ena_q),
        .wea_q    (wea_q),
        .addra_q  (addra_q),
        .dina_q   (dina_q)
    );

    fwd_quan #(.SHIFT(8)) u_q8 (.pcm(q8_pcm), .code(q8_code));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy,     0);
        check({tag, "_intr"},  intr,     0);
        check({tag, "_enpcm"}, en_pcm,   0);
        check({tag, "_addr"},  addr_pcm, 0);
        check({tag, "_wea"},   wea_q,    0);
        check({tag, "_ena"},   ena_q,    0);
        check({tag, "_addra"}, addra_q,  0);
        check({tag, "_dina"},  dina_q,   0);
    endtask

    // Starts a frame in the current cycle (T) and checks every cycle
    // T+1..T+FRAME_LEN+4. Returns in cycle T+FRAME_LEN+4 (IDLE).
    task automatic run_frame(input bit extra_starts);
        int nwr;
        int nbad;
        nwr  = 0;
        nbad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= FRAME_LEN + 4; c++) begin
            bit wr_exp;
            wr_exp = (c >= 3) && (c <= FRAME_LEN + 2);
            check("busy",     busy,     (c <= FRAME_LEN + 3));
            check("intr",     intr,     (c == FRAME_LEN + 3));
            check("en_pcm",   en_pcm,   (c <= FRAME_LEN));
            check("addr_pcm", addr_pcm, (c <= FRAME_LEN) ? c - 1 : 0);
            check("wea_q",    wea_q,    wr_exp);
            check("ena_q",    ena_q,    wr_exp);
            if (wr_exp) begin
                check("addra_q", addra_q, c - 3);
                check("dina_q",  dina_q,  pat_code[(c - 3) % 10]);
            end
            if (wea_q) nwr++;
            if (c < FRAME_LEN + 4) begin
                start = extra_starts && (c == 50 || c == FRAME_LEN + 3);
                tick();
                start = 1'b0;
            end
        end
        check("write_count", nwr, FRAME_LEN);
        $display("[TB] frame done: %0d writes, extra_starts=%0d", nwr, extra_starts);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) pcm_mem[i] = pat_pcm[i % 10];

        // 1. Reset with random start
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            check_all_zero("reset");
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        check_all_zero("idle");
        $display("[TB] reset sequence checked");

        // 3/4. Direct quantizer vectors at SHIFT=8
        q8_pcm = 16'h8180; #1; check("q8_8180", q8_code, 4'h2);
        q8_pcm = 16'h9000; #1; check("q8_9000", q8_code, 4'h7);
        q8_pcm = 16'h7000; #1; check("q8_7000", q8_code, 4'h8);
        q8_pcm = 16'h80FF; #1; check("q8_80FF", q8_code, 4'h1);
        $display("[TB] SHIFT=8 quantizer vectors checked");

        // 2/3/5. Frame with ignored starts, then back-to-back frame at T+260
        run_frame(1'b1);
        run_frame(1'b0);

        // 6. Mid-frame reset
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 101; c++) tick();
        check("mid_addr", addr_pcm, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_wea",  wea_q, 0);
            check("post_rst_intr", intr,  0);
            check("post_rst_busy", busy,  0);
        end
        $display("[TB] mid-frame reset checked");
        run_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
